// File: rtl/altusoc_wb2axi.sv
// altusoc_wb2axi: Wishbone-classic slave to single-beat AXI4 master bridge.
// Each Wishbone cycle becomes one 32-bit AXI4 read or write; the AXI response
// is returned as a one-cycle ack (OKAY/EXOKAY) or err (SLVERR/DECERR).
module altusoc_wb2axi #(
  parameter int              AW = 32,
  parameter int              IW = 3,
  parameter logic [IW-1:0]   ID = 3'b010
) (
  input  logic          clk,
  input  logic          rst_n,
  // Wishbone classic slave
  input  logic [AW-1:0] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err,
  // AXI4 write address
  output logic [IW-1:0] o_awid,
  output logic [AW-1:0] o_awaddr,
  output logic [7:0]    o_awlen,
  output logic [2:0]    o_awsize,
  output logic [1:0]    o_awburst,
  output logic          o_awvalid,
  input  logic          i_awready,
  // AXI4 write data
  output logic [31:0]   o_wdata,
  output logic [3:0]    o_wstrb,
  output logic          o_wlast,
  output logic          o_wvalid,
  input  logic          i_wready,
  // AXI4 write response
  input  logic [IW-1:0] i_bid,
  input  logic [1:0]    i_bresp,
  input  logic          i_bvalid,
  output logic          o_bready,
  // AXI4 read address
  output logic [IW-1:0] o_arid,
  output logic [AW-1:0] o_araddr,
  output logic [7:0]    o_arlen,
  output logic [2:0]    o_arsize,
  output logic [1:0]    o_arburst,
  output logic          o_arvalid,
  input  logic          i_arready,
  // AXI4 read data
  input  logic [31:0]   i_rdata,
  input  logic [IW-1:0] i_rid,
  input  logic [1:0]    i_rresp,
  input  logic          i_rlast,
  input  logic          i_rvalid,
  output logic          o_rready
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RRESP, DONE} state_e;

  state_e        state, state_nxt;
  logic [AW-1:0] addr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic [31:0]   rdt_q;
  logic          awvalid_q, wvalid_q, arvalid_q;
  logic          bready_q, rready_q;
  logic          ack_q, err_q;
  logic          unused_inputs;

  // Single-beat, word-sized INCR transactions with a fixed ID.
  assign o_awid    = ID;
  assign o_awaddr  = addr_q;
  assign o_awlen   = 8'd0;
  assign o_awsize  = 3'b010;
  assign o_awburst = 2'b01;
  assign o_awvalid = awvalid_q;
  assign o_wdata   = dat_q;
  assign o_wstrb   = sel_q;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = wvalid_q;
  assign o_bready  = bready_q;
  assign o_arid    = ID;
  assign o_araddr  = addr_q;
  assign o_arlen   = 8'd0;
  assign o_arsize  = 3'b010;
  assign o_arburst = 2'b01;
  assign o_arvalid = arvalid_q;
  assign o_rready  = rready_q;
  assign o_wb_rdt  = rdt_q;
  assign o_wb_ack  = ack_q;
  assign o_wb_err  = err_q;

  // IDs, rlast, byte-offset bits and the low response bit carry no information here.
  assign unused_inputs = ^{i_bid, i_rid, i_rlast, i_wb_adr[1:0], i_bresp[0], i_rresp[0]};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; WRITE leaves once both AW and W have handshaken, in any order.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (i_wb_cyc && i_wb_stb) state_nxt = i_wb_we ? WRITE : READ;
      WRITE: if ((!awvalid_q || i_awready) && (!wvalid_q || i_wready)) state_nxt = WRESP;
      WRESP: if (i_bvalid)  state_nxt = DONE;
      READ:  if (i_arready) state_nxt = RRESP;
      RRESP: if (i_rvalid)  state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered AXI handshake outputs, request latches and Wishbone termination.
  // ack/err are registered on the response handshake so they are visible while in
  // DONE; i_wb_cyc is sampled on that same edge to suppress termination after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rdt_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            addr_q <= {i_wb_adr[AW-1:2], 2'b00};
            dat_q  <= i_wb_dat;
            sel_q  <= i_wb_sel;
            if (i_wb_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              arvalid_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (i_awready) awvalid_q <= 1'b0;
          if (i_wready)  wvalid_q  <= 1'b0;
          if (state_nxt == WRESP) bready_q <= 1'b1;
        end
        WRESP: begin
          if (i_bvalid) begin
            bready_q <= 1'b0;
            ack_q    <= i_wb_cyc && !i_bresp[1];
            err_q    <= i_wb_cyc &&  i_bresp[1];
          end
        end
        READ: begin
          if (i_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        RRESP: begin
          if (i_rvalid) begin
            rready_q <= 1'b0;
            rdt_q    <= i_rdata;
            ack_q    <= i_wb_cyc && !i_rresp[1];
            err_q    <= i_wb_cyc &&  i_rresp[1];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_altusoc_wb2axi.sv
// Self-checking bench for altusoc_wb2axi: a configurable AXI slave, a scoreboard
// of expected Wishbone terminations and AXI requests, and a monitor that pops it.
module tb_altusoc_wb2axi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] i_wb_adr, i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we, i_wb_cyc, i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack, o_wb_err;
  logic [2:0]  o_awid, o_arid, i_bid, i_rid;
  logic [31:0] o_awaddr, o_araddr;
  logic [7:0]  o_awlen, o_arlen;
  logic [2:0]  o_awsize, o_arsize;
  logic [1:0]  o_awburst, o_arburst;
  logic        o_awvalid, i_awready, o_wvalid, i_wready, o_wlast;
  logic [31:0] o_wdata, i_rdata;
  logic [3:0]  o_wstrb;
  logic [1:0]  i_bresp, i_rresp;
  logic        i_bvalid, o_bready, o_arvalid, i_arready;
  logic        i_rlast, i_rvalid, o_rready;

  altusoc_wb2axi #(.AW(32), .IW(3), .ID(3'b010)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel), .i_wb_we(i_wb_we),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_rdt(o_wb_rdt), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
    .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize),
    .o_awburst(o_awburst), .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
    .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
    .o_arburst(o_arburst), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rid(i_rid), .i_rresp(i_rresp), .i_rlast(i_rlast),
    .i_rvalid(i_rvalid), .o_rready(o_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(string name, int cycles);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no response within %0d cycles", name, cycles);
  endfunction

  // Scoreboard queues, filled by the stimulus, emptied by the monitor.
  typedef struct { bit ack; bit rd; logic [31:0] rdt; } wb_exp_t;
  wb_exp_t     exp_wb[$];
  logic [31:0] exp_aw[$];
  logic [35:0] exp_w[$];
  logic [31:0] exp_ar[$];

  // Slave behaviour for the transaction in flight.
  int          s_aw_dly, s_w_dly, s_ar_dly, s_b_dly, s_r_dly;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  // Handshake counters kept by the monitor.
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
  int ar_run = 0, last_ar_run = 0;

  // AXI slave: readies after a per-channel delay, one response after each request.
  int aw_cnt, w_cnt, ar_cnt, b_wait, r_wait;
  bit aw_got, w_got, b_pend, r_pend, b_fire, r_fire;
  initial begin
    i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
    i_bresp = 0; i_rresp = 0; i_rdata = 0; i_bid = 3'b101; i_rid = 3'b011; i_rlast = 1;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i_awready = 0; i_wready = 0; i_arready = 0; i_bvalid = 0; i_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_fire = 0; r_fire = 0;
      end else begin
        if (b_fire) begin i_bvalid = 0; i_bresp = 2'($urandom); end
        if (r_fire) begin i_rvalid = 0; i_rdata = $urandom; i_rresp = 2'($urandom); end
        if (b_pend) begin
          if (b_wait == 0) begin i_bvalid = 1; i_bresp = s_bresp; b_pend = 0; end
          else b_wait--;
        end
        if (r_pend) begin
          if (r_wait == 0) begin i_rvalid = 1; i_rdata = s_rdata; i_rresp = s_rresp; r_pend = 0; end
          else r_wait--;
        end
        if (o_awvalid) begin i_awready = (aw_cnt >= s_aw_dly); aw_cnt++; end
        else begin i_awready = 0; aw_cnt = 0; end
        if (o_wvalid) begin i_wready = (w_cnt >= s_w_dly); w_cnt++; end
        else begin i_wready = 0; w_cnt = 0; end
        if (o_arvalid) begin i_arready = (ar_cnt >= s_ar_dly); ar_cnt++; end
        else begin i_arready = 0; ar_cnt = 0; end
        if (o_awvalid && i_awready) aw_got = 1;
        if (o_wvalid && i_wready) w_got = 1;
        if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_wait = s_b_dly; end
        if (o_arvalid && i_arready) begin r_pend = 1; r_wait = s_r_dly; end
        b_fire = i_bvalid && o_bready;
        r_fire = i_rvalid && o_rready;
      end
    end
  end

  // Monitor: pops expectations on every handshake / termination, checks valid stability.
  bit          aw_hold = 0, w_hold = 0, ar_hold = 0;
  logic [31:0] aw_prev, ar_prev;
  logic [35:0] w_prev;
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        aw_hold = 0; w_hold = 0; ar_hold = 0; ar_run = 0;
      end else begin
        if (aw_hold) chk("aw_stable", {o_awvalid, o_awaddr}, {1'b1, aw_prev});
        if (w_hold)  chk("w_stable",  {o_wvalid, o_wstrb, o_wdata}, {1'b1, w_prev});
        if (ar_hold) chk("ar_stable", {o_arvalid, o_araddr}, {1'b1, ar_prev});
        if (o_awvalid && i_awready) begin
          aw_hs++;
          if (exp_aw.size() > 0) begin
            chk("awaddr", o_awaddr, exp_aw.pop_front());
            chk("aw_const", {o_awid, o_awlen, o_awsize, o_awburst}, {3'b010, 8'h00, 3'b010, 2'b01});
          end else chk("aw_unexpected_hs", {o_awvalid, i_awready}, 2'b00);
        end
        if (o_wvalid && i_wready) begin
          w_hs++;
          if (exp_w.size() > 0) begin
            chk("wstrb_wdata", {o_wstrb, o_wdata}, exp_w.pop_front());
            chk("wlast", o_wlast, 1'b1);
          end else chk("w_unexpected_hs", {o_wvalid, i_wready}, 2'b00);
        end
        if (o_arvalid) ar_run++;
        if (o_arvalid && i_arready) begin
          ar_hs++;
          last_ar_run = ar_run;
          ar_run = 0;
          if (exp_ar.size() > 0) begin
            chk("araddr", o_araddr, exp_ar.pop_front());
            chk("ar_const", {o_arid, o_arlen, o_arsize, o_arburst}, {3'b010, 8'h00, 3'b010, 2'b01});
          end else chk("ar_unexpected_hs", {o_arvalid, i_arready}, 2'b00);
        end
        if (i_bvalid && o_bready) b_hs++;
        if (i_rvalid && o_rready) r_hs++;
        if (o_wb_ack || o_wb_err) begin
          if (exp_wb.size() > 0) begin
            e = exp_wb.pop_front();
            chk("wb_ack_err", {o_wb_ack, o_wb_err}, {e.ack, !e.ack});
            if (e.rd) chk("wb_rdt", o_wb_rdt, e.rdt);
          end else chk("wb_unexpected_term", {o_wb_ack, o_wb_err}, 2'b00);
        end
        aw_hold = o_awvalid && !i_awready; aw_prev = o_awaddr;
        w_hold  = o_wvalid && !i_wready;   w_prev  = {o_wstrb, o_wdata};
        ar_hold = o_arvalid && !i_arready; ar_prev = o_araddr;
      end
    end
  end

  // One Wishbone cycle; expected results come from the bridge's rules, and the
  // expected latency is 3 cycles plus the slave's stall cycles.
  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                         input logic we, input int aw_d, input int w_d, input int ar_d,
                         input int b_d, input int r_d, input logic [1:0] resp,
                         input logic [31:0] rdata, output int lat);
    wb_exp_t e;
    int      exp_lat;
    s_aw_dly = aw_d; s_w_dly = w_d; s_ar_dly = ar_d; s_b_dly = b_d; s_r_dly = r_d;
    s_bresp = resp; s_rresp = resp; s_rdata = rdata;
    e.ack = (resp[1] == 1'b0);
    e.rd  = !we;
    e.rdt = rdata;
    exp_wb.push_back(e);
    if (we) begin
      exp_aw.push_back(adr & 32'hFFFF_FFFC);
      exp_w.push_back({sel, dat});
      exp_lat = 3 + ((aw_d > w_d) ? aw_d : w_d) + b_d;
    end else begin
      exp_ar.push_back(adr & 32'hFFFF_FFFC);
      exp_lat = 3 + ar_d + r_d;
    end
    @(negedge clk);
    i_wb_adr = adr; i_wb_dat = dat; i_wb_sel = sel; i_wb_we = we;
    i_wb_cyc = 1; i_wb_stb = 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(o_wb_ack || o_wb_err) && lat < 200);
    if (!(o_wb_ack || o_wb_err)) timeout("wb_term", lat);
    else chk("wb_latency", lat, exp_lat);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, k, hs0, w0, r0;
    logic        r_we;
    logic [1:0]  r_resp;
    i_wb_adr = 0; i_wb_dat = 0; i_wb_sel = 0; i_wb_we = 0; i_wb_cyc = 0; i_wb_stb = 0;
    s_aw_dly = 0; s_w_dly = 0; s_ar_dly = 0; s_b_dly = 0; s_r_dly = 0;
    s_bresp = 0; s_rresp = 0; s_rdata = 0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}, 5'b0);
    chk("rst_wb", {o_wb_ack, o_wb_err}, 2'b00);
    chk("rst_rdt_addr", {o_wb_rdt, o_awaddr}, 64'h0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Minimum-latency write and read
    wb_xfer(32'h1000_0008, 32'hDEAD_BEEF, 4'hF, 1, 0, 0, 0, 0, 0, 2'b00, 32'h0, lat);
    wb_xfer(32'h1000_000B, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'hCAFE_F00D, lat);

    // Read with AR and R stalls
    wb_xfer(32'h2000_0104, 32'h0, 4'h0, 0, 0, 0, 5, 0, 3, 2'b00, 32'h1234_5678, lat);
    chk("ar_valid_cycles", last_ar_run, 6);

    // Skewed write channels: W four cycles before AW, then both together
    hs0 = aw_hs; w0 = w_hs;
    wb_xfer(32'h3000_0010, 32'hA5A5_0001, 4'h3, 1, 4, 0, 0, 0, 0, 2'b00, 32'h0, lat);
    chk("skew_aw_hs", aw_hs - hs0, 1);
    chk("skew_w_hs", w_hs - w0, 1);
    hs0 = aw_hs; w0 = w_hs;
    wb_xfer(32'h3000_0014, 32'hA5A5_0002, 4'hC, 1, 2, 2, 0, 1, 0, 2'b00, 32'h0, lat);
    chk("same_aw_hs", aw_hs - hs0, 1);
    chk("same_w_hs", w_hs - w0, 1);
    wb_xfer(32'h3000_0018, 32'hA5A5_0003, 4'h9, 1, 0, 3, 0, 0, 0, 2'b00, 32'h0, lat);

    // sel = 0 still issues the write
    wb_xfer(32'h3000_001C, 32'h5555_AAAA, 4'h0, 1, 0, 0, 0, 0, 0, 2'b00, 32'h0, lat);

    // Error and exclusive-okay responses
    wb_xfer(32'h4000_0000, 32'h0BAD_0BAD, 4'hF, 1, 0, 0, 0, 1, 0, 2'b10, 32'h0, lat);
    wb_xfer(32'h4000_0004, 32'h0, 4'h0, 0, 0, 0, 1, 0, 1, 2'b11, 32'hEEEE_0001, lat);
    wb_xfer(32'h4000_0008, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2, 2'b01, 32'h600D_D00D, lat);

    // Abort after the AR handshake: R is still accepted, no termination
    s_ar_dly = 1; s_r_dly = 3; s_rresp = 0; s_rdata = 32'h7777_8888;
    exp_ar.push_back(32'h5000_0020);
    hs0 = ar_hs; r0 = r_hs;
    @(negedge clk);
    i_wb_adr = 32'h5000_0022; i_wb_we = 0; i_wb_cyc = 1; i_wb_stb = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (ar_hs == hs0 && k < 50);
    if (ar_hs == hs0) timeout("abort_ar_hs", k);
    i_wb_cyc = 0; i_wb_stb = 0;
    k = 0;
    do begin @(negedge clk); k++; end while (r_hs == r0 && k < 50);
    if (r_hs == r0) timeout("abort_r_hs", k);
    repeat (4) @(negedge clk);
    chk("abort_r_count", r_hs - r0, 1);
    chk("abort_no_term_pending", exp_wb.size(), 0);
    wb_xfer(32'h5000_0030, 32'h1357_9BDF, 4'h6, 1, 1, 0, 0, 0, 0, 2'b00, 32'h0, lat);

    // Leave nonzero read data in o_wb_rdt before the reset test
    wb_xfer(32'h6000_0000, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b01, 32'h0BAD_F00D, lat);

    // Asynchronous reset while AW/W are pending
    s_aw_dly = 60; s_w_dly = 60;
    @(negedge clk);
    i_wb_adr = 32'h7000_0000; i_wb_dat = 32'hFFFF_0000; i_wb_sel = 4'hF; i_wb_we = 1;
    i_wb_cyc = 1; i_wb_stb = 1;
    k = 0;
    do begin @(negedge clk); k++; end while (!o_awvalid && k < 20);
    chk("pre_rst_valids", {o_awvalid, o_wvalid}, 2'b11);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready}, 5'b0);
    chk("async_rst_wb", {o_wb_ack, o_wb_err, o_wb_rdt}, 34'h0);
    chk("async_rst_addr", o_awaddr, 32'h0);
    i_wb_cyc = 0; i_wb_stb = 0; i_wb_we = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    wb_xfer(32'h7000_0044, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h2468_ACE0, lat);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r_we   = 1'($urandom);
      r_resp = 2'($urandom);
      wb_xfer($urandom, $urandom, 4'($urandom), r_we,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), r_resp, $urandom, lat);
    end

    repeat (5) @(negedge clk);
    chk("left_wb", exp_wb.size(), 0);
    chk("left_aw_w", {exp_aw.size(), exp_w.size()}, 64'h0);
    chk("left_ar", exp_ar.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/altusoc_wb2axi.md
# altusoc_wb2axi

Wishbone-classic slave to single-beat AXI4 master bridge, the complement of the AXI-to-Wishbone bridge feeding the SoC IO bus. It lets a Wishbone-side initiator (debug loader, DMA helper) reach the AXI interconnect through the host master port, which is otherwise tied off. Each Wishbone cycle becomes one 32-bit AXI4 read or write transaction. The block then returns ack or err on Wishbone.

## Interface
- AW, 32: address width of both sides.
- IW, 3: AXI ID width.
- ID, 3'b010: constant ID driven on o_awid and o_arid.
- clk  in  1  clock; every register is clocked on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_wb_adr  in  AW  byte address; bits [1:0] are ignored.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte selects.
- i_wb_we  in  1  write enable.
- i_wb_cyc, i_wb_stb  in  1 each  Wishbone cycle and strobe.
- o_wb_rdt  out  32  read data.
- o_wb_ack  out  1  one-cycle normal termination.
- o_wb_err  out  1  one-cycle error termination.
- o_awid  out  IW.
- o_awaddr  out  AW.
- o_awlen  out  8.
- o_awsize  out  3.
- o_awburst  out  2.
- o_awvalid  out  1.
- i_awready  in  1.
- o_wdata  out  32.
- o_wstrb  out  4.
- o_wlast  out  1.
- o_wvalid  out  1.
- i_wready  in  1.
- i_bid  in  IW.
- i_bresp  in  2.
- i_bvalid  in  1.
- o_bready  out  1.
- o_arid, o_araddr, o_arlen, o_arsize, o_arburst, o_arvalid, i_arready: AR channel; widths match the AW channel.
- i_rdata  in  32.
- i_rid  in  IW.
- i_rresp  in  2.
- i_rlast  in  1.
- i_rvalid  in  1.
- o_rready  out  1.
- Lock, cache, prot, region and qos are not ports; the instantiating module ties them to 0.

## Operation
- Constant outputs:
  - len = 0, size = 3'b010, burst = 2'b01 (INCR), wlast = 1.
  - awid = arid = ID.
  - Address = {i_wb_adr[AW-1:2], 2'b00}, registered at acceptance.
- States: IDLE, WRITE, WRESP, READ, RRESP, DONE.
- IDLE: when i_wb_cyc & i_wb_stb, latch address, data, sel and we.
  - we=1: go to WRITE and assert o_awvalid and o_wvalid.
  - we=0: go to READ and assert o_arvalid.
- WRITE:
  - Each valid drops the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - Go to WRESP once both have completed.
  - o_wstrb = latched sel; sel = 0 still issues the write.
- WRESP: o_bready = 1. On i_bvalid, capture i_bresp and go to DONE.
- READ: hold o_arvalid until i_arready, then go to RRESP.
- RRESP: o_rready = 1. On i_rvalid, capture i_rdata and i_rresp and go to DONE.
- DONE:
  - Drive o_wb_ack for one cycle if resp[1]=0 (OKAY or EXOKAY).
  - Otherwise drive o_wb_err for one cycle.
  - o_wb_rdt holds the captured read data; it is undefined (held) on writes.
  - Return to IDLE.
- i_bid, i_rid and i_rlast are ignored; single outstanding transaction only.
- Wishbone abort (i_wb_cyc falls mid-transaction): the AXI transaction runs to completion, because AXI cannot abort. In DONE, ack/err is suppressed if i_wb_cyc = 0.
- A new request is not sampled until the FSM is back in IDLE. Requests arriving in DONE are taken the following cycle.

## Timing
- Reset values:
  - All valid/ready outputs = 0.
  - o_wb_ack = o_wb_err = 0.
  - o_wb_rdt = 0; latched address/data = 0.
  - State = IDLE.
- All outputs are registered; there is no combinational path from AXI inputs to AXI outputs.
- AXI rules:
  - A valid, once high, stays high with stable payload until ready.
  - Valid never depends on ready.
- Minimum latency, slave ready at once and response one cycle after handshake:
  - Write: stb sampled at cycle N, AW/W handshake at N+1, B handshake at N+2, ack at N+3.
  - Read: same pattern, with AR and R in place of AW/W and B.
- A reset assertion mid-transaction returns to IDLE immediately and drops all valids.

## Test plan
- Write: adr 0x1000_0008, dat 0xDEADBEEF, sel 0xF, all-ready slave, bresp OKAY -> awaddr 0x1000_0008, wdata 0xDEADBEEF, wstrb 0xF, ack exactly at N+3, err=0.
- Read with stalls: arready delayed 5 cycles, rvalid delayed 3 more, rdata 0x12345678 -> arvalid held steady for 6 cycles, o_wb_rdt = 0x12345678 with one-cycle ack.
- Skewed write channels: wready granted 4 cycles before awready, and in a second run both in the same cycle -> exactly one AW and one W handshake each, ack once.
- Error responses: bresp 2'b10 on a write, rresp 2'b11 on a read -> o_wb_err one cycle, no ack; rresp 2'b01 (EXOKAY) -> ack.
- Abort: drop i_wb_cyc after AR handshake -> R still accepted, no ack/err; next request processed normally.
- Reset: assert rst_n low while awvalid is pending -> all valids 0 in the same cycle (asynchronous); after release, FSM is IDLE and a fresh read completes.
